// File: rtl/mips32_seq_pkg.sv
// rtl/mips32_seq_pkg.sv - shared types and constants for the mips32 instruction sequencer
package mips32_seq_pkg;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      FINISH
   } seq_state_t;
endpackage

// File: rtl/mips32_instr_sequencer_seq_ram.sv
// rtl/mips32_instr_sequencer_seq_ram.sv - DEPTHx32 array, one synchronous write port, one asynchronous read port
module seq_ram
   import mips32_seq_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);
   logic [INSTR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/mips32_instr_sequencer.sv
// rtl/mips32_instr_sequencer.sv - program feeder and result collector in front of the mips32 core
module mips32_instr_sequencer
   import mips32_seq_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int GAP    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               start,
   input  logic [ADDR_W:0]    count,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   input  logic [INSTR_W-1:0] result,
   output logic               busy,
   output logic               done,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [INSTR_W-1:0] rd_data
);
   localparam int GC_W = (GAP > 1) ? $clog2(GAP) : 1;

   seq_state_t         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [GC_W-1:0]    gc_q, gc_d;
   logic [ADDR_W:0]    count_q, count_d;
   logic [INSTR_W-1:0] instruction_q, instruction_d;
   logic [INSTR_W-1:0] rd_data_q, rd_data_d;

   logic               prog_we, res_we;
   logic [ADDR_W-1:0]  prog_raddr;
   logic [INSTR_W-1:0] prog_rdata, res_rdata;
   logic [ADDR_W:0]    count_clamped;
   logic               slot_end, last_slot;

   assign prog_we       = load_en && (state_q != ISSUE) && !reset;
   assign slot_end      = (gc_q == GC_W'(GAP - 1));
   assign last_slot     = ({1'b0, pc_q} == (count_q - (ADDR_W+1)'(1)));
   assign res_we        = (state_q == ISSUE) && slot_end && !reset;
   assign prog_raddr    = (state_q == ISSUE) ? pc_q + ADDR_W'(1) : '0;
   assign count_clamped = (count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : count;

   seq_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_prog (
      .clk   (clk),
      .we    (prog_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (prog_raddr),
      .rdata (prog_rdata)
   );

   seq_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_res (
      .clk   (clk),
      .we    (res_we),
      .waddr (pc_q),
      .wdata (result),
      .raddr (rd_addr),
      .rdata (res_rdata)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      gc_d          = gc_q;
      count_d       = count_q;
      instruction_d = instruction_q;
      rd_data_d     = res_rdata;
      case (state_q)
         IDLE: begin
            if (start) begin
               count_d = count_clamped;
               if (count_clamped == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d = ISSUE;
                  pc_d    = '0;
                  gc_d    = '0;
                  // A same-cycle load to word 0 must be seen by the first slot.
                  instruction_d = (prog_we && (load_addr == '0)) ? load_data : prog_rdata;
               end
            end
         end
         ISSUE: begin
            if (slot_end) begin
               gc_d = '0;
               if (last_slot) begin
                  state_d       = FINISH;
                  instruction_d = NOP_INSTR;
               end else begin
                  pc_d          = pc_q + ADDR_W'(1);
                  instruction_d = prog_rdata;
               end
            end else begin
               gc_d = gc_q + GC_W'(1);
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         gc_q          <= '0;
         count_q       <= '0;
         instruction_q <= NOP_INSTR;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         gc_q          <= gc_d;
         count_q       <= count_d;
         instruction_q <= instruction_d;
         rd_data_q     <= rd_data_d;
      end
   end

   assign instruction = instruction_q;
   assign instr_valid = (state_q == ISSUE);
   assign busy        = (state_q == ISSUE);
   assign done        = (state_q == FINISH);
   assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_mips32_instr_sequencer.sv
// tb/tb_mips32_instr_sequencer.sv - scoreboard bench for mips32_instr_sequencer with a behavioural core stub
module tb_mips32_instr_sequencer;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int GAP    = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              load_en = 1'b0;
   logic [ADDR_W-1:0] load_addr = '0;
   logic [31:0]       load_data = '0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   count = '0;
   logic [31:0]       instruction;
   logic              instr_valid;
   logic [31:0]       result = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [31:0]       rd_data;

   mips32_instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP(GAP)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .start       (start),
      .count       (count),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .result      (result),
      .busy        (busy),
      .done        (done),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Core stub: fixed register values, R-type ALU, result only settles after GAP cycles.
   function automatic logic [31:0] reg_val(input logic [4:0] r);
      return ({27'h0, r} * 32'h0135_79BD) + 32'h0F0F_1234;
   endfunction

   function automatic logic [31:0] core_alu(input logic [31:0] ins);
      logic [31:0] a, b;
      a = reg_val(ins[25:21]);
      b = reg_val(ins[20:16]);
      case (ins[5:0])
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h2a:   return {31'h0, $signed(a) < $signed(b)};
         default: return 32'h0;
      endcase
   endfunction

   logic [31:0] prev_i = '0;
   int          age = 0;
   always @(negedge clk) begin
      if (instruction === prev_i) age++;
      else age = 1;
      prev_i = instruction;
      result = (age >= GAP) ? core_alu(instruction) : (32'hBAD0_0000 | 32'(age));
   end

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_iq[$];
   exp_t        exp_rq[$];
   int          exp_dq[$];
   logic [31:0] prog_m [DEPTH];
   logic [31:0] res_m  [DEPTH];
   bit          mon_en = 1'b0;

   always @(negedge clk) begin : monitor
      exp_t e;
      int   dc;
      if (mon_en) begin
         while (exp_iq.size() > 0 && exp_iq[0].cyc < cyc) begin
            e = exp_iq.pop_front();
            chk("missed_issue_cycle", 32'(cyc), 32'(e.cyc));
         end
         if (instr_valid) begin
            if (exp_iq.size() == 0) chk("unexpected_instr_valid", 32'd1, 32'd0);
            else begin
               e = exp_iq.pop_front();
               chk("issue_cycle", 32'(cyc), 32'(e.cyc));
               chk("instruction", instruction, e.val);
            end
            chk("busy_in_slot", {31'h0, busy}, 32'd1);
         end else begin
            chk("idle_instruction_nop", instruction, 32'h0);
            chk("idle_busy", {31'h0, busy}, 32'd0);
         end
         while (exp_dq.size() > 0 && exp_dq[0] < cyc) begin
            dc = exp_dq.pop_front();
            chk("missed_done_cycle", 32'(cyc), 32'(dc));
         end
         if (done === 1'b1) begin
            if (exp_dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               dc = exp_dq.pop_front();
               chk("done_cycle", 32'(cyc), 32'(dc));
            end
         end else if (done !== 1'b0) begin
            chk("done_known", {31'h0, done}, 32'd0);
         end
         while (exp_rq.size() > 0 && exp_rq[0].cyc < cyc) begin
            e = exp_rq.pop_front();
            chk("missed_rd_check", 32'(cyc), 32'(e.cyc));
         end
         if (exp_rq.size() > 0 && exp_rq[0].cyc == cyc) begin
            e = exp_rq.pop_front();
            chk("rd_data", rd_data, e.val);
         end
      end
   end

   function automatic logic [31:0] rand_instr();
      logic [5:0] f;
      case ($urandom_range(0, 4))
         0:       f = 6'h20;
         1:       f = 6'h22;
         2:       f = 6'h24;
         3:       f = 6'h25;
         default: f = 6'h2a;
      endcase
      return {6'h0, 15'($urandom), 5'h0, f};
   endfunction

   task automatic load(input int a, input logic [31:0] d);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = ADDR_W'(a);
      load_data = d;
      prog_m[a] = d;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   // reset_at: relative cycle in which reset is held high (-1 = none)
   task automatic run(input int cnt, input int reset_at, input bit disturb,
                      input bit load0, input logic [31:0] d0);
      int n, c0, end_rel, cy;
      n = (cnt > DEPTH) ? DEPTH : cnt;
      @(negedge clk);
      c0    = cyc;
      start = 1'b1;
      count = 5'(cnt);
      if (load0) begin
         load_en   = 1'b1;
         load_addr = '0;
         load_data = d0;
         prog_m[0] = d0;
      end
      for (int k = 0; k < n; k++) begin
         for (int g = 0; g < GAP; g++) begin
            cy = 1 + k * GAP + g;
            if (reset_at < 0 || cy <= reset_at) exp_iq.push_back('{cyc: c0 + cy, val: prog_m[k]});
         end
         if (reset_at < 0 || (k + 1) * GAP < reset_at) res_m[k] = core_alu(prog_m[k]);
      end
      if (reset_at < 0) exp_dq.push_back(c0 + n * GAP + 1);
      else exp_rq.push_back('{cyc: c0 + reset_at + 1, val: 32'h0});
      end_rel = (reset_at < 0) ? n * GAP + 2 : reset_at + 1;
      for (int i = 1; i <= end_rel; i++) begin
         @(negedge clk);
         start   = 1'b0;
         load_en = 1'b0;
         if (disturb && i == 4) begin
            start     = 1'b1;
            load_en   = 1'b1;
            load_addr = ADDR_W'(1);
            load_data = rand_instr() ^ 32'h0000_0100;
         end
         reset = (i == reset_at);
      end
   endtask

   task automatic read_all(input int n);
      for (int a = 0; a < n; a++) begin
         @(negedge clk);
         rd_addr = ADDR_W'(a);
         exp_rq.push_back('{cyc: cyc + 1, val: res_m[a]});
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc, nl;
      reset = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      exp_rq.push_back('{cyc: cyc + 1, val: 32'h0});
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      load(0, 32'h0085_8022);
      load(1, 32'h00a6_2020);
      load(2, 32'h00e8_3824);
      run(3, -1, 1'b0, 1'b0, 32'h0);
      read_all(3);

      run(0, -1, 1'b0, 1'b0, 32'h0);

      run(3, -1, 1'b1, 1'b0, 32'h0);
      run(3, -1, 1'b0, 1'b0, 32'h0);
      read_all(3);

      for (int a = 0; a < DEPTH; a++) load(a, rand_instr());
      run(17, -1, 1'b0, 1'b0, 32'h0);
      read_all(DEPTH);

      load(0, rand_instr());
      load(1, rand_instr());
      run(3, 5, 1'b0, 1'b0, 32'h0);
      read_all(3);
      run(3, -1, 1'b0, 1'b0, 32'h0);
      read_all(3);

      run(2, -1, 1'b0, 1'b1, rand_instr());
      read_all(2);

      for (int t = 0; t < 6; t++) begin
         nl = $urandom_range(1, DEPTH);
         for (int a = 0; a < nl; a++) load(a, rand_instr());
         rc = $urandom_range(0, DEPTH + 1);
         run(rc, -1, 1'b0, 1'b0, 32'h0);
         read_all((rc > nl) ? nl : rc);
      end

      repeat (3) @(negedge clk);
      chk("leftover_expectations", 32'(exp_iq.size() + exp_dq.size() + exp_rq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mips32_instr_sequencer.md
# mips32_instr_sequencer

Hardware instruction feeder and result collector for the single-cycle `mips32` datapath. It holds a small program memory loaded over a write port, issues one R-type instruction per fixed-length slot into the core's `instruction` input, and captures the core's `result` at the end of each slot into a result buffer. It replaces file-driven stimulus for on-chip runs and self-checking benches, and sits directly in front of the core.

## Interface
- `DEPTH`, 16: program and result buffer entries.
- `ADDR_W`, 4: address width, log2(DEPTH).
- `GAP`, 3: clk cycles per instruction slot. Must be at least 1.
- `clk`  in  1  sole clock; all logic rises on posedge.
- `reset`  in  1  synchronous, active-high.
- `load_en`  in  1  write `load_data` to program[`load_addr`]. Ignored while `busy`.
- `load_addr`  in  ADDR_W  program write address.
- `load_data`  in  32  instruction word.
- `start`  in  1  begin a run. Sampled only in IDLE.
- `count`  in  ADDR_W+1  number of instructions to run, 0..DEPTH. Values above DEPTH clamp to DEPTH. Latched at start.
- `instruction`  out  32  to core `instruction`. Holds 32'h0 (NOP) when not issuing.
- `instr_valid`  out  1  high during every cycle of an issue slot.
- `result`  in  32  from core `result`. Combinational in the core.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `rd_addr`  in  ADDR_W  result buffer read address.
- `rd_data`  out  32  result[`rd_addr`], registered, 1-cycle latency.

## Operation
- FSM states: IDLE, ISSUE, FINISH.
- IDLE → ISSUE on `start` with latched count ≥ 1. On that edge, load pc=0, the gap counter gc=0, and `instruction`=program[0].
- IDLE → FINISH on `start` with count=0. No issue.
- In ISSUE, gc counts 0..GAP-1. At gc=GAP-1:
  - write `result` to resbuf[pc];
  - if pc=count-1, go to FINISH;
  - otherwise pc++, gc=0, and `instruction`=program[pc+1].
- FINISH: assert `done` for one cycle, then go to IDLE.
- `busy`=1 in ISSUE. `busy`=0 in IDLE and FINISH.
- `start` while busy, or in FINISH, is ignored and not queued.
- `load_en` while busy is dropped.
- `load_en` and `start` in the same IDLE cycle: the write happens first. The run sees the new word if it targets address 0.
- `rd_addr` reads are allowed at any time. A read of the entry being written in the same cycle returns the old value.
- Width rules:
  - pc is ADDR_W bits and does not wrap within a run, because count ≤ DEPTH.
  - The clamp compares the full ADDR_W+1 bits.
- Reset in any state, mid-run included, on the next edge:
  - state=IDLE, pc=0, gc=0, `instruction`=0, `instr_valid`=0, `busy`=0, `done`=0, `rd_data`=0;
  - program and result buffer contents are not cleared.

## Timing
- Reset values: all outputs 0.
- Label the cycle in which `start` is sampled as cycle 0.
- Slot k, for k=0..count-1, occupies cycles 1+k·GAP through (k+1)·GAP. `instruction`=program[k] and `instr_valid`=1 throughout the slot.
- resbuf[k] is written at the posedge that ends cycle (k+1)·GAP.
- `done`=1 in cycle count·GAP+1. `instruction` returns to 0 and `instr_valid` to 0 in that same cycle.
- Earliest next accepted `start`: cycle count·GAP+2.
- count=0: `done` in cycle 1.
- Effective issue rate is 1/GAP. GAP=3 gives the core two settle cycles before capture.

## Structure
- Shared package `mips32_seq_pkg` holds:
  - the state enum `seq_state_t` (IDLE, ISSUE, FINISH);
  - `NOP_INSTR`=32'h0;
  - the instruction width constant, 32.
- Sub-module `seq_ram` is a DEPTH×32 array with one synchronous write port, one asynchronous read port and no reset. Instantiate it twice: program memory and result buffer.
- The registered `rd_data` and `instruction` flops live in the top level.

## Test plan
- Program load and run:
  - stimulus: load 3 words (0x00858022 sub, 0x00a62020 add, 0x00e83824 and), count=3, GAP=3, start at cycle 0;
  - required: `instruction` equals each word for 3 cycles (cycles 1–3, 4–6, 7–9), `done` in cycle 10, resbuf[0..2] match the core model.
- Zero count:
  - stimulus: count=0 and start;
  - required: `done` in cycle 1, `instr_valid` never high, `busy` never high.
- Ignored commands:
  - stimulus: start and load_en to address 1 (new data) in cycle 4 of a 3-instruction run;
  - required: no restart, `done` still in cycle 10, program[1] unchanged on a later run.
- Count clamp:
  - stimulus: count=17 with DEPTH=16;
  - required: exactly 16 slots, `done` in cycle 49, `instruction`=0 afterwards.
- Reset mid-run:
  - stimulus: reset high in cycle 5 of a 3-instruction run;
  - required: all outputs 0 on the next cycle, resbuf[0] retains its cycle-3 capture, a fresh start runs normally.
- Read port:
  - stimulus: `rd_addr`=2 after a run;
  - required: `rd_data` equals resbuf[2] exactly one cycle later.
